// File: rtl/quant_block.sv
// Quantizer for one 4x4 block: one zigzag position per cycle, levels out in zigzag order, reconstruction in raster order.
// Optional feature macro: QUANT_SHARPEN_EN (adds sharpen[j] to |coeff[j]| before thresholding).
module quant_block #(
    parameter int BLOCK_SIZE = 4,
    parameter int LEVEL_MAX  = 2047
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [12*BLOCK_SIZE*BLOCK_SIZE-1:0]       coeff,
    input  logic [12*BLOCK_SIZE*BLOCK_SIZE-1:0]       q,
    input  logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0]       iq,
    input  logic [18*BLOCK_SIZE*BLOCK_SIZE-1:0]       bias,
    input  logic [12*BLOCK_SIZE*BLOCK_SIZE-1:0]       zthresh,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]        sharpen,
    output logic                                      busy,
    output logic [12*BLOCK_SIZE*BLOCK_SIZE-1:0]       levels,
    output logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0]       rec,
    output logic                                      nz,
    output logic                                      done
);
    localparam int N = BLOCK_SIZE * BLOCK_SIZE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            nz_acc_q, nz_acc_d;
    logic            nz_q, nz_d;
    logic [12*N-1:0] coeff_r_q, coeff_r_d;
    logic [12*N-1:0] q_r_q, q_r_d;
    logic [16*N-1:0] iq_r_q, iq_r_d;
    logic [18*N-1:0] bias_r_q, bias_r_d;
    logic [12*N-1:0] zth_r_q, zth_r_d;
    logic [12*N-1:0] levels_q, levels_d;
    logic [16*N-1:0] rec_q, rec_d;

    function automatic logic [3:0] zz_index(input logic [3:0] n);
        case (n)
            4'd0:  zz_index = 4'd0;
            4'd1:  zz_index = 4'd1;
            4'd2:  zz_index = 4'd4;
            4'd3:  zz_index = 4'd8;
            4'd4:  zz_index = 4'd5;
            4'd5:  zz_index = 4'd2;
            4'd6:  zz_index = 4'd3;
            4'd7:  zz_index = 4'd6;
            4'd8:  zz_index = 4'd9;
            4'd9:  zz_index = 4'd12;
            4'd10: zz_index = 4'd13;
            4'd11: zz_index = 4'd10;
            4'd12: zz_index = 4'd7;
            4'd13: zz_index = 4'd11;
            4'd14: zz_index = 4'd14;
            default: zz_index = 4'd15;
        endcase
    endfunction

    logic [3:0]  j;
    logic [11:0] c_j, q_j, zth_j;
    logic [15:0] iq_j;
    logic [17:0] bias_j;
    logic [7:0]  sh_j;
    logic        neg;
    logic [12:0] mag, m;
    logic [29:0] prod;
    logic [12:0] lvl_raw;
    logic [11:0] lvl_mag, lvl_s;
    logic [15:0] rec_u, rec_s;

`ifdef QUANT_SHARPEN_EN
    logic [8*N-1:0] sharpen_r_q, sharpen_r_d;
    assign sh_j = sharpen_r_q[int'(j)*8 +: 8];
`else
    logic unused_sharpen;
    assign unused_sharpen = ^sharpen;
    assign sh_j = 8'd0;
`endif

    // Datapath for the coefficient currently addressed by the zigzag counter.
    always_comb begin
        j       = zz_index(cnt_q);
        c_j     = coeff_r_q[int'(j)*12 +: 12];
        q_j     = q_r_q[int'(j)*12 +: 12];
        iq_j    = iq_r_q[int'(j)*16 +: 16];
        bias_j  = bias_r_q[int'(j)*18 +: 18];
        zth_j   = zth_r_q[int'(j)*12 +: 12];
        neg     = c_j[11];
        mag     = neg ? 13'(-{c_j[11], c_j}) : {c_j[11], c_j};
        m       = mag + {5'd0, sh_j};
        prod    = {17'd0, m} * {14'd0, iq_j} + {12'd0, bias_j};
        lvl_raw = 13'(prod >> 17);
        lvl_mag = 12'd0;
        if (m > {1'b0, zth_j}) begin
            lvl_mag = (lvl_raw > 13'(LEVEL_MAX)) ? 12'(LEVEL_MAX) : lvl_raw[11:0];
        end
        lvl_s = neg ? 12'(-lvl_mag) : lvl_mag;
        rec_u = 16'({12'd0, lvl_mag} * {12'd0, q_j});
        rec_s = neg ? 16'(-rec_u) : rec_u;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nz_acc_d  = nz_acc_q;
        nz_d      = nz_q;
        coeff_r_d = coeff_r_q;
        q_r_d     = q_r_q;
        iq_r_d    = iq_r_q;
        bias_r_d  = bias_r_q;
        zth_r_d   = zth_r_q;
        levels_d  = levels_q;
        rec_d     = rec_q;
`ifdef QUANT_SHARPEN_EN
        sharpen_r_d = sharpen_r_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    coeff_r_d = coeff;
                    q_r_d     = q;
                    iq_r_d    = iq;
                    bias_r_d  = bias;
                    zth_r_d   = zthresh;
`ifdef QUANT_SHARPEN_EN
                    sharpen_r_d = sharpen;
`endif
                    nz_acc_d  = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                levels_d[int'(cnt_q)*12 +: 12] = lvl_s;
                rec_d[int'(j)*16 +: 16]        = rec_s;
                nz_acc_d = nz_acc_q | (lvl_mag != 12'd0);
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    nz_d    = nz_acc_q | (lvl_mag != 12'd0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            nz_acc_q  <= 1'b0;
            nz_q      <= 1'b0;
            coeff_r_q <= '0;
            q_r_q     <= '0;
            iq_r_q    <= '0;
            bias_r_q  <= '0;
            zth_r_q   <= '0;
            levels_q  <= '0;
            rec_q     <= '0;
`ifdef QUANT_SHARPEN_EN
            sharpen_r_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nz_acc_q  <= nz_acc_d;
            nz_q      <= nz_d;
            coeff_r_q <= coeff_r_d;
            q_r_q     <= q_r_d;
            iq_r_q    <= iq_r_d;
            bias_r_q  <= bias_r_d;
            zth_r_q   <= zth_r_d;
            levels_q  <= levels_d;
            rec_q     <= rec_d;
`ifdef QUANT_SHARPEN_EN
            sharpen_r_q <= sharpen_r_d;
`endif
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign nz     = nz_q;
    assign levels = levels_q;
    assign rec    = rec_q;

endmodule

// File: tb/tb_quant_block.sv
// Bench for quant_block: directed and random blocks checked against an arithmetic reference model.
// Honours QUANT_SHARPEN_EN in the model so it matches whichever build is under test.
module tb_quant_block;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [191:0] coeff;
  logic [191:0] q;
  logic [255:0] iq;
  logic [287:0] bias;
  logic [191:0] zthresh;
  logic [127:0] sharpen;
  logic         busy;
  logic [191:0] levels;
  logic [255:0] rec;
  logic         nz;
  logic         done;

  quant_block dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coeff(coeff), .q(q), .iq(iq),
    .bias(bias), .zthresh(zthresh), .sharpen(sharpen), .busy(busy),
    .levels(levels), .rec(rec), .nz(nz), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int c_a[16], q_a[16], iq_a[16], bias_a[16], zt_a[16], sh_a[16];
  int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  logic [191:0] exp_levels;
  logic [255:0] exp_rec;
  logic         exp_nz;
  logic [191:0] cap_levels;
  logic [255:0] cap_rec;
  logic         cap_nz;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: straight arithmetic on integers, raster in, zigzag out
  task automatic model();
    longint m, l, r;
    exp_levels = '0;
    exp_rec    = '0;
    exp_nz     = 1'b0;
    for (int n = 0; n < 16; n++) begin
      int k;
      k = zz[n];
      m = (c_a[k] < 0) ? -c_a[k] : c_a[k];
`ifdef QUANT_SHARPEN_EN
      m = m + sh_a[k];
`endif
      if (m > zt_a[k]) begin
        l = (m * iq_a[k] + bias_a[k]) / 131072;
        if (l > 2047) l = 2047;
      end else begin
        l = 0;
      end
      r = l * q_a[k];
      if (c_a[k] < 0) begin
        l = -l;
        r = -r;
      end
      exp_levels[n*12 +: 12] = 12'(l);
      exp_rec[k*16 +: 16]    = 16'(r);
      if (l != 0) exp_nz = 1'b1;
    end
  endtask

  task automatic set_uniform(input int qv, input int iqv, input int bv, input int ztv, input int shv);
    for (int k = 0; k < 16; k++) begin
      c_a[k] = 0; q_a[k] = qv; iq_a[k] = iqv; bias_a[k] = bv; zt_a[k] = ztv; sh_a[k] = shv;
    end
  endtask

  task automatic set_random(input bit sparse);
    for (int k = 0; k < 16; k++) begin
      c_a[k]    = int'($urandom_range(0, 4095)) - 2048;
      if (sparse && $urandom_range(0, 3) != 0) c_a[k] = int'($urandom_range(0, 20)) - 10;
      q_a[k]    = int'($urandom_range(3, 4095));
      iq_a[k]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : 131072 / q_a[k];
      bias_a[k] = int'($urandom_range(0, 262143));
      zt_a[k]   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 300));
      sh_a[k]   = int'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_ports();
    for (int k = 0; k < 16; k++) begin
      coeff[k*12 +: 12]   = 12'(c_a[k]);
      q[k*12 +: 12]       = 12'(q_a[k]);
      iq[k*16 +: 16]      = 16'(iq_a[k]);
      bias[k*18 +: 18]    = 18'(bias_a[k]);
      zthresh[k*12 +: 12] = 12'(zt_a[k]);
      sharpen[k*8 +: 8]   = 8'(sh_a[k]);
    end
  endtask

  // driver: returns at the falling edge of cycle 1 (start sampled on edge 0)
  task automatic launch();
    @(negedge clk);
    drive_ports();
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_block(input string tag, input int extra_start_at);
    int  done_at;
    int  pulses;
    bit  busy_ok;
    done_at = -1;
    pulses  = 0;
    busy_ok = 1'b1;
    launch();
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) begin
          done_at    = c;
          cap_levels = levels;
          cap_rec    = rec;
          cap_nz     = nz;
        end
      end
      if (busy !== ((c <= 16) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (c == extra_start_at) begin
        start = 1'b1;
        coeff = {6{32'h5a5a_a5a5}};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 256'(done_at), 256'(17));
    check({tag, "_busy"}, 256'(busy_ok), 256'(1));
    check({tag, "_pulses"}, 256'(pulses), 256'(1));
    check({tag, "_levels"}, 256'(cap_levels), 256'(exp_levels));
    check({tag, "_rec"}, cap_rec, exp_rec);
    check({tag, "_nz"}, 256'(cap_nz), 256'(exp_nz));
    check({tag, "_hold"}, 256'(levels), 256'(exp_levels));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    set_uniform(10, 13107, 65536, 0, 0);
    drive_ports();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_nz", 256'(nz), 256'(0));
    check("rst_levels", 256'(levels), 256'(0));
    check("rst_rec", rec, 256'(0));

    set_uniform(10, 13107, 65536, 0, 0);
    run_block("zero", 0);

    set_uniform(10, 13107, 65536, 0, 0);
    c_a[0] = 100;
    run_block("pos100", 0);
    check("pos100_lvl0", 256'(levels[11:0]), 256'(12'd10));

    set_uniform(10, 13107, 65536, 0, 0);
    c_a[0] = -100;
    run_block("neg100", 0);
    check("neg100_lvl0", 256'(levels[11:0]), 256'(12'hFF6));
    check("neg100_rec0", 256'(rec[15:0]), 256'(16'hFF9C));

    set_uniform(10, 13107, 65536, 0, 0);
    c_a[4] = 100;
    run_block("zigzag", 0);
    check("zigzag_lvl2", 256'(levels[35:24]), 256'(12'd10));

    set_uniform(10, 13107, 65536, 0, 0);
    c_a[0] = 5; zt_a[0] = 5; sh_a[0] = 1;
    run_block("thresh", 0);

    set_uniform(4095, 65535, 262143, 0, 255);
    for (int k = 0; k < 16; k++) c_a[k] = -2048;
    run_block("extreme", 0);

    set_random(1'b0);
    run_block("start_busy", 5);
    set_random(1'b0);
    run_block("start_done", 17);

    // reset mid-block
    set_random(1'b0);
    launch();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_levels", 256'(levels), 256'(0));
    check("abort_rec", rec, 256'(0));
    check("abort_nz", 256'(nz), 256'(0));
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 256'(pulses), 256'(0));
    set_random(1'b0);
    run_block("after_abort", 0);

    for (int i = 0; i < 12; i++) begin
      set_random(i[0]);
      run_block($sformatf("rand%0d", i), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
